// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_pkg
// Brief    : Shared state encoding, segment patterns and prescaler width for
//            the 7-segment counter sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

  localparam int PRESC_W = 29;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Active-low patterns, left-most bit is segment a, right-most is g.
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/counter_sequencer_ctrl_seg7_decoder_n.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decoder_n
// Brief    : Combinational 4-bit value to active-low 7-segment decoder;
//            values above 9 blank the digit.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decoder_n
  import counter_seq_pkg::*;
(
  input  logic [3:0] value,
  output logic [0:6] seg
);

  always_comb begin
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/counter_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer_ctrl
// Brief    : Run/pause/clear sequencer with rate prescaler and count register
//            driving one HEX digit. Define COUNTER_SEQ_DIR_CTRL_EN to add the
//            dir input (1 = count down).
// Revision : 1.0 - initial release
// ============================================================================
module counter_sequencer_ctrl
  import counter_seq_pkg::*;
#(
  parameter logic [PRESC_W-1:0] RATE0     = 29'd25000000,
  parameter logic [PRESC_W-1:0] RATE1     = 29'd50000000,
  parameter logic [PRESC_W-1:0] RATE2     = 29'd100000000,
  parameter logic [PRESC_W-1:0] RATE3     = 29'd300000000,
  parameter logic [3:0]         MAX_COUNT = 4'd9
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       oneshot,
`ifdef COUNTER_SEQ_DIR_CTRL_EN
  input  logic       dir,
`endif
  input  logic [1:0] rate_sel,
  output logic [3:0] count,
  output logic       tick,
  output logic       busy,
  output logic       done,
  output logic [0:6] HEX
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_PAUSE = PAUSE;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]         r_state,  w_state_nxt;
  logic [PRESC_W-1:0] r_presc,  w_presc_nxt;
  logic [3:0]         r_count,  w_count_nxt;
  logic               r_tick,   w_tick_nxt;
  logic               r_busy;
  logic               r_done;
  logic [1:0]         r_rate_sel;
  logic [PRESC_W-1:0] w_rate;
  logic [PRESC_W-1:0] w_rate_m1;
  logic               w_dir;
  logic [3:0]         w_reload;

`ifdef COUNTER_SEQ_DIR_CTRL_EN
  logic r_dir;

  // Remembers the direction of the last tick so DONE->start reloads the
  // correct end of the range.
  always_ff @(posedge CLOCK_50) begin
    if (RESET)           r_dir <= 1'b0;
    else if (w_tick_nxt) r_dir <= dir;
  end

  assign w_dir    = dir;
  assign w_reload = r_dir ? MAX_COUNT : 4'd0;
`else
  assign w_dir    = 1'b0;
  assign w_reload = 4'd0;
`endif

  always_comb begin
    case (rate_sel)
      2'd0:    w_rate = RATE0;
      2'd1:    w_rate = RATE1;
      2'd2:    w_rate = RATE2;
      default: w_rate = RATE3;
    endcase
  end

  assign w_rate_m1 = w_rate - PRESC_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_count_nxt = r_count;
    w_tick_nxt  = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_count_nxt = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = '0;
          end
        end
        S_RUN: begin
          // start outranks pause, and start while running is a no-op.
          if (pause && !start) begin
            w_state_nxt = S_PAUSE;
          end else if (rate_sel != r_rate_sel) begin
            w_presc_nxt = '0;
          end else if (r_presc == w_rate_m1) begin
            w_presc_nxt = '0;
            w_tick_nxt  = 1'b1;
            if (!w_dir) begin
              if (r_count < MAX_COUNT) w_count_nxt = r_count + 4'd1;
              else if (oneshot)        w_state_nxt = S_DONE;
              else                     w_count_nxt = 4'd0;
            end else begin
              if (r_count != 4'd0)     w_count_nxt = r_count - 4'd1;
              else if (oneshot)        w_state_nxt = S_DONE;
              else                     w_count_nxt = MAX_COUNT;
            end
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
        end
        S_PAUSE: begin
          if (start) w_state_nxt = S_RUN;
        end
        S_DONE: begin
          if (start) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = '0;
            w_count_nxt = w_reload;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_count    <= 4'd0;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rate_sel <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_count    <= w_count_nxt;
      r_tick     <= w_tick_nxt;
      r_busy     <= (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_DONE);
      r_rate_sel <= rate_sel;
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign busy  = r_busy;
  assign done  = r_done;

  seg7_decoder_n u_seg7 (
    .value (r_count),
    .seg   (HEX)
  );

endmodule
`default_nettype wire

// File: doc/counter_sequencer_ctrl.md
Name: counter_sequencer_ctrl

Overview:
- Run-control sequencer for the board's 7-segment digit counter.
- Owns the rate prescaler, the run/pause/clear state machine and the count register, and drives one HEX digit.
- Takes single-cycle command pulses from the pushbutton/switch front end and a 2-bit rate select from SW.
- Produces the count, a tick strobe, status flags and active-low segment drive.

Parameters:
- RATE0, 29'd25000000, clock cycles per tick for rate_sel=00
- RATE1, 29'd50000000, cycles per tick for rate_sel=01
- RATE2, 29'd100000000, cycles per tick for rate_sel=10
- RATE3, 29'd300000000, cycles per tick for rate_sel=11
- MAX_COUNT, 4'd9, terminal count value (legal range 1..9)

Ports:
- CLOCK_50  input  1  system clock, all logic on its rising edge
- RESET  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse: start or resume
- pause  input  1  single-cycle pulse: freeze count
- clear  input  1  single-cycle pulse: return to IDLE with count 0
- oneshot  input  1  level; 1 = stop at MAX_COUNT, 0 = wrap
- rate_sel  input  2  tick-rate select, indexes RATE0..RATE3
- count  output  4  current count value
- tick  output  1  one-cycle pulse on each count update
- busy  output  1  high while in RUN
- done  output  1  high while in DONE
- HEX  output  [0:6]  segments a..g, active-low (0 = lit)

Behaviour:
- Clock and reset are fixed: one clock, CLOCK_50. RESET is synchronous and active-high.
- Reset values:
  - state = IDLE
  - count = 0
  - prescaler = 0
  - tick = 0, busy = 0, done = 0
  - HEX = 7'b0000001 (digit 0)
- FSM states: IDLE, RUN, PAUSE, DONE.
- Command priority when pulses coincide: clear > start > pause. Only the highest-priority command is acted on.
- IDLE:
  - start -> RUN, with prescaler = 0.
  - pause is ignored.
- RUN: prescaler increments every cycle. When prescaler == RATE[rate_sel]-1:
  - prescaler returns to 0 and a tick event occurs.
  - If count < MAX_COUNT: count + 1.
  - If count == MAX_COUNT and oneshot=0: count wraps to 0.
  - If count == MAX_COUNT and oneshot=1: count holds and state -> DONE.
  - pause -> PAUSE; prescaler value is kept.
  - clear -> IDLE; count and prescaler go to 0.
- PAUSE:
  - Prescaler and count are frozen.
  - start -> RUN and resumes from the held prescaler value.
  - clear -> IDLE.
- DONE:
  - count holds MAX_COUNT.
  - start -> RUN with count = 0 and prescaler = 0.
  - clear -> IDLE.
- Timing of tick and count:
  - tick is registered and is high in the same cycle the new count appears.
  - First tick comes exactly RATE cycles after the start pulse is sampled.
- Events on the same edge:
  - If a command (pause/clear) lands on the tick edge, the command wins and no count update occurs.
  - A tick edge with start in RUN is a normal tick.
- rate_sel change while in RUN:
  - A registered copy of rate_sel is compared each cycle; on a mismatch, prescaler resets to 0 that cycle and no tick fires.
  - The new rate applies to the next full period.
- Arithmetic:
  - prescaler is 29 bits unsigned.
  - The terminal compare uses == against the selected rate minus 1. No >= drift, no extra cycle per period.
- Status outputs:
  - busy = (state == RUN), registered.
  - done = (state == DONE), registered.
- HEX is combinational from count. Values >9 blank the digit (7'b1111111).
- Mid-operation RESET has the same effect as power-up reset on the next edge, overriding all commands.

Optional Feature:
- Macro: COUNTER_SEQ_DIR_CTRL_EN
- Defined:
  - Adds input port dir (1 bit); 1 = count down.
  - Counting down: count goes MAX_COUNT..0.
  - At 0 it wraps to MAX_COUNT when oneshot=0, or enters DONE holding 0 when oneshot=1.
  - DONE->start reloads count = MAX_COUNT.
  - dir is sampled only on tick edges.
- Undefined: no dir port; up-count only, exactly as above.

Decomposition:
- Package counter_seq_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3)
  - segment constants SEG_0..SEG_9 and SEG_BLANK
  - prescaler width constant PRESC_W = 29
- One sub-module, seg7_decoder_n: 4-bit value in, [0:6] active-low segments out, purely combinational.
- The FSM, prescaler and count stay in counter_sequencer_ctrl.

Test Plan:
- Bench parameters: RATE0..RATE3 = 4, 6, 8, 10 and MAX_COUNT = 3.
- RESET high 2 cycles -> count=0, busy=0, done=0, tick=0, HEX=7'b0000001.
- rate_sel=00, oneshot=0, start -> tick every 4 cycles, first at cycle 4. count 1,2,3,0,1. busy=1 throughout.
- oneshot=1, start -> count reaches 3 at cycle 12. Then done=1, busy=0, count holds 3, no further ticks. A start pulse -> count=0, RUN.
- RUN, pause at cycle 6 (prescaler=1 after the first tick), hold 20 cycles, then start -> next tick 3 cycles after resume. count continues from 1 to 2.
- clear and start on the same cycle in RUN -> IDLE, count=0, no tick. rate_sel 00->11 mid-period -> no tick that cycle, next tick 10 cycles later.
- With COUNTER_SEQ_DIR_CTRL_EN, dir=1, oneshot=0 -> count 0,3,2,1,0,3 on successive ticks.
